// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to add the i_par_type port and the PARITY state.
module uart_tx_frame #(
   parameter int PRESCALE   = 8,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [BYTE_WIDTH-1:0]      i_data,
   input  logic                       i_data_valid,
   output logic                       o_ready,
   input  logic [$clog2(PRESCALE):0]  i_prescale,
`ifdef UART_TX_PARITY_EN
   input  logic                       i_par_type,
`endif
   output logic                       o_tx,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam int PW  = $clog2(PRESCALE) + 1;
   localparam int BCW = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
   localparam logic [PW-1:0]  P_MAX    = PW'(PRESCALE);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(BYTE_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t                  state_reg;
   logic [BYTE_WIDTH-1:0]   shift_reg;
   logic [PW-1:0]           p_last_reg;
   logic [PW-1:0]           edge_cnt_reg;
   logic [BCW-1:0]          bit_cnt_reg;
   logic                    tx_reg;
   logic                    busy_reg;
   logic                    done_reg;
`ifdef UART_TX_PARITY_EN
   logic                    parity_reg;
`endif

   logic [PW-1:0]           p_eff;
   logic [BYTE_WIDTH-1:0]   shift_next;
   logic                    bit_end;

   // Zero or out-of-range prescale falls back to the slowest legal rate.
   assign p_eff      = ((i_prescale == '0) || (i_prescale > P_MAX)) ? P_MAX : i_prescale;
   assign shift_next = shift_reg >> 1;
   assign bit_end    = (edge_cnt_reg == p_last_reg);

   assign o_ready = (state_reg == IDLE);
   assign o_tx    = tx_reg;
   assign o_busy  = busy_reg;
   assign o_done  = done_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         p_last_reg   <= '0;
         edge_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         if (state_reg != IDLE) begin
            edge_cnt_reg <= bit_end ? '0 : edge_cnt_reg + 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (i_data_valid) begin
                  shift_reg    <= i_data;
                  p_last_reg   <= p_eff - 1'b1;
                  edge_cnt_reg <= '0;
                  bit_cnt_reg  <= '0;
                  tx_reg       <= 1'b0;
                  busy_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  parity_reg   <= (^i_data) ^ i_par_type;
`endif
                  state_reg    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx_reg    <= shift_reg[0];
                  state_reg <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt_reg == BIT_LAST) begin
                     bit_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_reg      <= parity_reg;
                     state_reg   <= PARITY;
`else
                     tx_reg      <= 1'b1;
                     state_reg   <= STOP;
`endif
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     shift_reg   <= shift_next;
                     tx_reg      <= shift_next[0];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  tx_reg    <= 1'b1;
                  state_reg <= STOP;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  tx_reg    <= 1'b1;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: begin
               tx_reg    <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
